ssram_ctrl: RTL and testbench
=============================

// Module: ssram_ctrl
// PURPOSE
//  Pipelined synchronous-SSRAM controller downstream of the bus arbiter. Converts single reads/writes and
//  fixed 4-beat read bursts into ADSC/ADV-sequenced SSRAM cycles. Drives both SSRAM banks and handles
//  read latency and read->write bus turnaround. Returns waitrequest/readdatavalid to the arbiter.
// PARAMETERS
//  ADDR_W    21  word-address width; bit ADDR_W-1 selects bank (0->ce0, 1->ce1)
//  READ_LAT  2   clocks from ADSC# edge to data captured from ssram_din (pipelined part)
//  BURST_LEN 4   beats per read burst; power of two, address wraps within the BURST_LEN-aligned block
// PORTS
//  clk           in   1       system clock; SSRAM clocked from same edge
//  reset         in   1       synchronous, active-high
//  address       in   ADDR_W  word address from arbiter
//  read          in   1       read request (level, held until !waitrequest)
//  write         in   1       write request (level, held until !waitrequest)
//  burst         in   1       with read: BURST_LEN-beat burst
//  writedata     in   32      write data
//  be            in   4       byte enables, active high
//  readdata      out  32      registered read data
//  readdatavalid out  1       one pulse per returned beat
//  waitrequest   out  1       high while a request is not yet completed
//  ssram_addr    out  ADDR_W-1
//  ssram_dout    out  32      data to pads
//  ssram_dout_en out  1       pad output enable (top builds the tri-state)
//  ssram_din     in   32      data from pads
//  ssram_ce0_n, ssram_ce1_n, ssram_we_n, ssram_oe_n, ssram_adsc_n, ssram_adv_n  out 1 each
//  ssram_be_n    out  4
// BEHAVIOUR
//  - Reset: FSM=IDLE; all *_n outputs 1; readdata=0, readdatavalid=0, waitrequest=1, ssram_dout_en=0.
//    Reset mid-operation aborts at once. No beat is delivered after the reset cycle.
//  - waitrequest is 1 whenever the FSM is not completing the current request.
//    In IDLE with no request, waitrequest is 1.
//  - All SSRAM pin outputs are registered. Pin addr = address[ADDR_W-2:0]. The bank CE is latched at command.
//  - FSM states: IDLE, WR, RD_CMD, RD_WAIT, TURN.
//  - IDLE->WR on write (and no read).
//    WR, 1 cycle: adsc_n=0, we_n=0, be_n=~be, dout_en=1, waitrequest=0. Then ->IDLE.
//  - IDLE->RD_CMD on read. Read has priority if read and write are both high; the write stays pending.
//    RD_CMD: adsc_n=0, oe_n=0. Then ->RD_WAIT.
//    For burst, the next BURST_LEN-1 cycles drive adv_n=0 (one per beat).
//  - Beat k is captured READ_LAT clocks after its address edge (a small shift register of valid tags).
//    readdata<=ssram_din and readdatavalid=1 in the capture cycle.
//    Single read: latency from accepting edge to readdatavalid = READ_LAT+1 clocks.
//  - waitrequest drops together with the readdatavalid of the last beat (single: the only beat).
//    Then ->TURN.
//  - TURN, 1 cycle: oe_n=1, dout_en=0, waitrequest=1. Guarantees one dead cycle before any pad drive.
//    Then ->IDLE. A write after a write needs no TURN.
//  - Burst wrap: beat address low log2(BURST_LEN) bits = (start+k) mod BURST_LEN (SSRAM linear mode).
//    The upper bits are unchanged. A start at offset 3 returns 3,0,1,2.
//  - be=0000 on write: a full cycle still runs with be_n=1111. Memory is unchanged; waitrequest completes normally.
//  - read/write dropped before completion (protocol violation): the current operation still finishes.
//    No extra beats are issued.
//  - dout_en=1 only in WR. oe_n and dout_en are never both active.
// STRUCTURE
//  - Shared package ssram_pkg: state encoding localparams (IDLE..TURN), BURST_LEN, READ_LAT defaults,
//    pin-idle constant (all *_n=1).
//  - Sub-module ssram_rdpipe: READ_LAT-deep valid/last-tag shift register.
//    Produces the capture strobe and the last-beat flag. The rest is one FSM plus a beat counter.
// TESTING
//  1. Reset held 3 clocks, then released -> all *_n=1, waitrequest=1, readdatavalid=0. No pad drive.
//  2. Write addr 0x000010, data 0xDEADBEEF, be=1111; then read addr 0x000010
//     -> readdatavalid exactly READ_LAT+1 clocks after the read accept edge, readdata=0xDEADBEEF.
//     TURN precedes the next write.
//  3. Write be=0101, data 0x11223344, over 0xFFFFFFFF; then read -> 0xFF22FF44.
//  4. Burst read at word 0x3 of the preloaded pattern w[i]=i -> beats 3,0,1,2 on 4 consecutive clocks.
//     adv_n low for 3 clocks; waitrequest low only on the 4th beat.
//  5. read and write high together -> read is serviced first. The write is completed after TURN, with one dead pad cycle between.
//  6. reset asserted on the 2nd beat of a burst -> the next cycle is idle. No further readdatavalid; ce_n=1.
//     The next single read behaves as in test 2.
//  Checker: assert oe_n==0 and dout_en==1 never true together.
//  Bank select: address MSB=1 -> only ce1_n active.

Source files
------------

// File: rtl/ssram_pkg.sv
// Shared definitions for the pipelined SSRAM controller: state encoding,
// default geometry and the registered pin bundle with its idle value.
package ssram_pkg;

  localparam int ADDR_W_DEF    = 21;
  localparam int READ_LAT_DEF  = 2;
  localparam int BURST_LEN_DEF = 4;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE    = 3'd0;
  localparam state_t ST_WR      = 3'd1;
  localparam state_t ST_RD_CMD  = 3'd2;
  localparam state_t ST_RD_WAIT = 3'd3;
  localparam state_t ST_TURN    = 3'd4;

  typedef struct packed {
    logic       ce0_n;
    logic       ce1_n;
    logic       we_n;
    logic       oe_n;
    logic       adsc_n;
    logic       adv_n;
    logic [3:0] be_n;
  } pins_t;

  // Every strobe deasserted: the bus-idle pin state.
  localparam pins_t PIN_IDLE = 10'h3FF;

endpackage

// File: rtl/ssram_rdpipe.sv
// Read-latency tracker: a DEPTH-deep shift register of beat-valid and
// last-beat tags, producing the capture strobe for returning read data.
module ssram_rdpipe #(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic in_valid,
  input  logic in_last,
  output logic cap,
  output logic cap_last
);

  logic [DEPTH-1:0] v_q;
  logic [DEPTH-1:0] l_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      v_q <= '0;
      l_q <= '0;
    end else begin
      v_q[0] <= in_valid;
      l_q[0] <= in_valid & in_last;
      for (int i = 1; i < DEPTH; i++) begin
        v_q[i] <= v_q[i-1];
        l_q[i] <= l_q[i-1];
      end
    end
  end

  assign cap      = v_q[DEPTH-1];
  assign cap_last = v_q[DEPTH-1] & l_q[DEPTH-1];

endmodule

// File: rtl/ssram_ctrl.sv
// Pipelined synchronous-SSRAM controller: turns arbiter single reads/writes
// and wrapping read bursts into ADSC/ADV pin cycles on two SSRAM banks.
module ssram_ctrl
  import ssram_pkg::*;
#(
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int READ_LAT  = READ_LAT_DEF,
  parameter int BURST_LEN = BURST_LEN_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] address,
  input  logic              read,
  input  logic              write,
  input  logic              burst,
  input  logic [31:0]       writedata,
  input  logic [3:0]        be,
  output logic [31:0]       readdata,
  output logic              readdatavalid,
  output logic              waitrequest,
  output logic [ADDR_W-2:0] ssram_addr,
  output logic [31:0]       ssram_dout,
  output logic              ssram_dout_en,
  input  logic [31:0]       ssram_din,
  output logic              ssram_ce0_n,
  output logic              ssram_ce1_n,
  output logic              ssram_we_n,
  output logic              ssram_oe_n,
  output logic              ssram_adsc_n,
  output logic              ssram_adv_n,
  output logic [3:0]        ssram_be_n,
  output logic [2:0]        dbg_state
);

  // Handshake: read/write (with address, burst, data, be) are held by the
  // arbiter until a cycle with waitrequest low; the request completes on that
  // clock edge. For reads that cycle is also the last readdatavalid beat.

  localparam int OFF_W = $clog2(BURST_LEN);
  localparam int CNT_W = OFF_W + 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(BURST_LEN);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BURST_LEN - 1);

  state_t            state, state_d;
  pins_t             pins_q, pins_d;
  logic [ADDR_W-2:0] addr_q, addr_d;
  logic [31:0]       dout_q, dout_d;
  logic              dout_en_q, dout_en_d;
  logic [CNT_W-1:0]  cnt_q;
  logic              burst_q;
  logic              issue_last_q, issue_last_d;
  logic              adv_d;
  logic              wait_q, wait_d;
  logic [31:0]       rdata_q;
  logic              rdv_q, rd_last_q;
  logic              issue, cap, cap_last;

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_d;
  end

  always_comb begin
    state_d = state;
    case (state)
      ST_IDLE: begin
        if (read)       state_d = ST_RD_CMD;
        else if (write) state_d = ST_WR;
      end
      ST_WR:      state_d = ST_IDLE;
      ST_RD_CMD:  state_d = ST_RD_WAIT;
      ST_RD_WAIT: if (rd_last_q) state_d = ST_TURN;
      ST_TURN:    state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Pin values for the next cycle; registered below so every pad is a flop.
  always_comb begin
    pins_d       = PIN_IDLE;
    addr_d       = addr_q;
    dout_d       = dout_q;
    dout_en_d    = 1'b0;
    adv_d        = 1'b0;
    issue_last_d = 1'b0;
    wait_d       = !cap_last;
    case (state)
      ST_IDLE: begin
        if (read) begin
          pins_d.ce0_n  = address[ADDR_W-1];
          pins_d.ce1_n  = !address[ADDR_W-1];
          pins_d.adsc_n = 1'b0;
          pins_d.oe_n   = 1'b0;
          addr_d        = address[ADDR_W-2:0];
          issue_last_d  = !burst;
        end else if (write) begin
          pins_d.ce0_n  = address[ADDR_W-1];
          pins_d.ce1_n  = !address[ADDR_W-1];
          pins_d.adsc_n = 1'b0;
          pins_d.we_n   = 1'b0;
          pins_d.be_n   = ~be;
          addr_d        = address[ADDR_W-2:0];
          dout_d        = writedata;
          dout_en_d     = 1'b1;
          wait_d        = 1'b0;
        end
      end
      ST_RD_CMD, ST_RD_WAIT: begin
        if (!rd_last_q) begin
          pins_d.ce0_n = pins_q.ce0_n;
          pins_d.ce1_n = pins_q.ce1_n;
          pins_d.oe_n  = 1'b0;
          if (burst_q && cnt_q != CNT_FULL) begin
            // Linear burst: only the offset inside the aligned block advances.
            adv_d        = 1'b1;
            pins_d.adv_n = 1'b0;
            addr_d       = {addr_q[ADDR_W-2:OFF_W], addr_q[OFF_W-1:0] + OFF_W'(1)};
            issue_last_d = (cnt_q == CNT_LAST);
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pins_q       <= PIN_IDLE;
      addr_q       <= '0;
      dout_q       <= '0;
      dout_en_q    <= 1'b0;
      cnt_q        <= '0;
      burst_q      <= 1'b0;
      issue_last_q <= 1'b0;
      wait_q       <= 1'b1;
      rdata_q      <= '0;
      rdv_q        <= 1'b0;
      rd_last_q    <= 1'b0;
    end else begin
      pins_q       <= pins_d;
      addr_q       <= addr_d;
      dout_q       <= dout_d;
      dout_en_q    <= dout_en_d;
      issue_last_q <= issue_last_d;
      wait_q       <= wait_d;
      rdv_q        <= cap;
      rd_last_q    <= cap_last;
      if (cap) rdata_q <= ssram_din;
      if (state == ST_IDLE && read) begin
        cnt_q   <= CNT_W'(1);
        burst_q <= burst;
      end else if (adv_d) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  // A read beat is on the pins whenever ADSC (read) or ADV is asserted.
  assign issue = (!pins_q.adsc_n && !pins_q.oe_n) || !pins_q.adv_n;

  ssram_rdpipe #(.DEPTH(READ_LAT)) u_rdpipe (
    .clk      (clk),
    .reset    (reset),
    .in_valid (issue),
    .in_last  (issue_last_q),
    .cap      (cap),
    .cap_last (cap_last)
  );

  assign readdata      = rdata_q;
  assign readdatavalid = rdv_q;
  assign waitrequest   = wait_q;
  assign ssram_addr    = addr_q;
  assign ssram_dout    = dout_q;
  assign ssram_dout_en = dout_en_q;
  assign ssram_ce0_n   = pins_q.ce0_n;
  assign ssram_ce1_n   = pins_q.ce1_n;
  assign ssram_we_n    = pins_q.we_n;
  assign ssram_oe_n    = pins_q.oe_n;
  assign ssram_adsc_n  = pins_q.adsc_n;
  assign ssram_adv_n   = pins_q.adv_n;
  assign ssram_be_n    = pins_q.be_n;
  assign dbg_state     = state;

endmodule

// File: tb/tb_ssram_ctrl.sv
// Bench for ssram_ctrl: pipelined SSRAM pad model, directed drivers and a
// scoreboard monitor checking data, latency, waitrequest and pin rules.
module tb_ssram_ctrl;

  localparam int READ_LAT = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [20:0] address = '0;
  logic        read = 1'b0, write = 1'b0, burst = 1'b0;
  logic [31:0] writedata = '0;
  logic [3:0]  be = '0;
  logic [31:0] readdata;
  logic        readdatavalid, waitrequest;
  logic [19:0] ssram_addr;
  logic [31:0] ssram_dout;
  logic        ssram_dout_en;
  logic [31:0] ssram_din = '0;
  logic        ssram_ce0_n, ssram_ce1_n, ssram_we_n, ssram_oe_n, ssram_adsc_n, ssram_adv_n;
  logic [3:0]  ssram_be_n;
  logic [2:0]  dbg_state;

  ssram_ctrl dut (
    .clk(clk), .reset(reset), .address(address), .read(read), .write(write),
    .burst(burst), .writedata(writedata), .be(be), .readdata(readdata),
    .readdatavalid(readdatavalid), .waitrequest(waitrequest),
    .ssram_addr(ssram_addr), .ssram_dout(ssram_dout), .ssram_dout_en(ssram_dout_en),
    .ssram_din(ssram_din), .ssram_ce0_n(ssram_ce0_n), .ssram_ce1_n(ssram_ce1_n),
    .ssram_we_n(ssram_we_n), .ssram_oe_n(ssram_oe_n), .ssram_adsc_n(ssram_adsc_n),
    .ssram_adv_n(ssram_adv_n), .ssram_be_n(ssram_be_n), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset / cycle count
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state
  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];
  int          exp_cyc_q[$];
  bit          exp_last_q[$];
  logic [20:0] exp_addr = '0;
  logic [31:0] exp_wdata = '0;
  logic [3:0]  exp_be = '0;
  int          adv_cnt = 0;
  int          last_oe_cyc = -100;
  logic        prev_dout_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- SSRAM model: 2-stage pipelined read, byte-masked write
  logic [31:0] mem [logic [20:0]];
  logic [31:0] stage1 = '0;
  always @(posedge clk) begin
    logic [20:0] k;
    logic rd;
    rd = 1'b0;
    k = {!ssram_ce1_n, ssram_addr};
    if (!ssram_adsc_n && (!ssram_ce0_n || !ssram_ce1_n)) begin
      if (!ssram_we_n) begin
        logic [31:0] w;
        w = mem.exists(k) ? mem[k] : 32'h0;
        for (int b = 0; b < 4; b++)
          if (!ssram_be_n[b]) w[8*b +: 8] = ssram_dout[8*b +: 8];
        mem[k] = w;
      end else rd = 1'b1;
    end else if (!ssram_adv_n) rd = 1'b1;
    stage1    <= rd ? (mem.exists(k) ? mem[k] : 32'hxxxxxxxx) : 32'hxxxxxxxx;
    ssram_din <= stage1;
  end

  // ---------------- monitor
  always @(negedge clk) begin
    if (readdatavalid) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL rdv_unexpected actual=%h expected=no beat (cycle %0d)", readdata, cyc);
      end else begin
        logic [31:0] e;
        int c;
        bit l;
        e = exp_q.pop_front();
        c = exp_cyc_q.pop_front();
        l = exp_last_q.pop_front();
        check("readdata", readdata, e);
        check("rd_latency_cycle", cyc, c);
        check("wait_on_beat", {31'b0, waitrequest}, {31'b0, !l});
      end
    end else if (!waitrequest) begin
      check("wait_low_only_in_wr", {31'b0, ssram_dout_en}, 32'd1);
    end
    check("oe_dout_excl", {31'b0, !ssram_oe_n && ssram_dout_en}, 32'd0);
    if (!ssram_adsc_n) begin
      check("cmd_addr", {12'b0, ssram_addr}, {12'b0, exp_addr[19:0]});
      check("cmd_bank", {30'b0, ssram_ce0_n, ssram_ce1_n}, {30'b0, exp_addr[20], !exp_addr[20]});
    end
    if (!ssram_we_n) begin
      check("wr_be_n", {28'b0, ssram_be_n}, {28'b0, ~exp_be});
      check("wr_dout", ssram_dout, exp_wdata);
      check("wr_dout_en", {31'b0, ssram_dout_en}, 32'd1);
    end
    if (ssram_dout_en && !prev_dout_en)
      check("dead_cycle", {31'b0, (cyc - last_oe_cyc) >= 2}, 32'd1);
    if (!ssram_oe_n) last_oe_cyc = cyc;
    if (!ssram_adv_n) adv_cnt++;
    prev_dout_en = ssram_dout_en;
  end

  // ---------------- driver tasks
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input string what);
    int n;
    n = 0;
    @(negedge clk);
    while (waitrequest && n < 40) begin
      @(negedge clk);
      n++;
    end
    check({what, "_done"}, {31'b0, waitrequest}, 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic push_beats(input logic [31:0] e0, e1, e2, e3, input int n, input bit has_last);
    int acc;
    logic [31:0] ev [4];
    ev[0] = e0; ev[1] = e1; ev[2] = e2; ev[3] = e3;
    acc = cyc + 1;
    for (int k = 0; k < n; k++) begin
      exp_q.push_back(ev[k]);
      exp_cyc_q.push_back(acc + READ_LAT + 1 + k);
      exp_last_q.push_back(has_last && (k == n - 1));
    end
  endtask

  task automatic do_write(input logic [20:0] a, input logic [31:0] d, input logic [3:0] b);
    exp_addr = a; exp_wdata = d; exp_be = b;
    address = a; writedata = d; be = b; write = 1'b1;
    wait_done("write");
    write = 1'b0;
  endtask

  task automatic do_read(input logic [20:0] a, input logic brst,
                         input logic [31:0] e0, e1, e2, e3);
    idle(2);
    push_beats(e0, e1, e2, e3, brst ? 4 : 1, 1'b1);
    exp_addr = a;
    address = a; burst = brst; read = 1'b1;
    wait_done("read");
    read = 1'b0; burst = 1'b0;
  endtask

  task automatic do_both(input logic [20:0] a, input logic [31:0] d, input logic [31:0] e_rd);
    idle(2);
    push_beats(e_rd, 0, 0, 0, 1, 1'b1);
    exp_addr = a; exp_wdata = d; exp_be = 4'hF;
    address = a; writedata = d; be = 4'hF; read = 1'b1; write = 1'b1;
    wait_done("both_read");
    read = 1'b0;
    wait_done("both_write");
    write = 1'b0;
  endtask

  // ---------------- directed sequence
  initial begin
    int adv0;
    int n;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_pins_n", {22'b0, ssram_ce0_n, ssram_ce1_n, ssram_we_n, ssram_oe_n,
          ssram_adsc_n, ssram_adv_n, ssram_be_n}, 32'h3FF);
    check("rst_wait", {31'b0, waitrequest}, 32'd1);
    check("rst_rdv", {31'b0, readdatavalid}, 32'd0);
    check("rst_dout_en", {31'b0, ssram_dout_en}, 32'd0);
    check("rst_readdata", readdata, 32'd0);
    reset = 1'b0;
    idle(2);
    check("idle_pins_n", {22'b0, ssram_ce0_n, ssram_ce1_n, ssram_we_n, ssram_oe_n,
          ssram_adsc_n, ssram_adv_n, ssram_be_n}, 32'h3FF);
    check("idle_wait", {31'b0, waitrequest}, 32'd1);

    // write then single read back
    do_write(21'h000010, 32'hDEADBEEF, 4'hF);
    do_read(21'h000010, 1'b0, 32'hDEADBEEF, 0, 0, 0);

    // partial byte enables
    do_write(21'h000020, 32'hFFFFFFFF, 4'hF);
    do_write(21'h000020, 32'h11223344, 4'b0101);
    do_read(21'h000020, 1'b0, 32'hFF22FF44, 0, 0, 0);

    // wrapping burst from offset 3
    for (int i = 0; i < 4; i++) mem[21'(i)] = 32'(i);
    adv0 = adv_cnt;
    do_read(21'h000003, 1'b1, 32'd3, 32'd0, 32'd1, 32'd2);
    check("burst_adv_count", adv_cnt - adv0, 32'd3);

    // read wins over a simultaneous write, write follows after turnaround
    do_both(21'h000010, 32'hCAFEF00D, 32'hDEADBEEF);
    do_read(21'h000010, 1'b0, 32'hCAFEF00D, 0, 0, 0);

    // empty byte enables leave memory untouched
    do_write(21'h000010, 32'h12345678, 4'b0000);
    do_read(21'h000010, 1'b0, 32'hCAFEF00D, 0, 0, 0);

    // upper bank
    do_write(21'h100010, 32'hA5A5A5A5, 4'hF);
    do_read(21'h100010, 1'b0, 32'hA5A5A5A5, 0, 0, 0);
    do_read(21'h000010, 1'b0, 32'hCAFEF00D, 0, 0, 0);

    // reset on the 2nd beat of a burst
    idle(2);
    push_beats(32'd0, 32'd1, 0, 0, 2, 1'b0);
    exp_addr = 21'h000000;
    address = 21'h000000; burst = 1'b1; read = 1'b1;
    n = 0;
    @(negedge clk);
    while (!readdatavalid && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("abort_first_beat_seen", {31'b0, readdatavalid}, 32'd1);
    @(posedge clk);
    #1;
    reset = 1'b1; read = 1'b0; burst = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("abort_rdv", {31'b0, readdatavalid}, 32'd0);
      check("abort_pins_n", {27'b0, ssram_ce0_n, ssram_ce1_n, ssram_oe_n, ssram_adsc_n,
            ssram_adv_n}, 32'h1F);
      check("abort_wait", {31'b0, waitrequest}, 32'd1);
      check("abort_state", {29'b0, dbg_state}, 32'd0);
    end
    @(posedge clk);
    #1;
    do_read(21'h000010, 1'b0, 32'hCAFEF00D, 0, 0, 0);

    idle(6);
    check("exp_q_empty", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=still running expected=finished");
    $fatal(1, "watchdog");
  end

endmodule
